// File: rtl/upsampling_pkg.sv
// Shared definitions for the upsampling datapath: bus widths, packer phase
// encodings and a clog2 helper for sizing counters.
package upsampling_pkg;

    localparam int PIX_W  = 24;
    localparam int AXIS_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pixel_to_axis_packer.sv
// Packs 24-bit RGB pixels into 32-bit little-endian AXI4-Stream words (4 pixels -> 3 words)
// with TLAST per line. Optional PACKER_SOF_TUSER_EN adds pix_sof/m_axis_tuser and SOF resync.
module pixel_to_axis_packer
    import upsampling_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_WIDTH      = 24,
    parameter int LINE_PIXELS      = 3840
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PIXEL_WIDTH-1:0]      pix_in,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
`ifdef PACKER_SOF_TUSER_EN
    ,
    input  logic                        pix_sof,
    output logic                        m_axis_tuser
`endif
);

    localparam int CNT_W = (clog2(LINE_PIXELS) < 1) ? 1 : clog2(LINE_PIXELS);

    generate
        if (LINE_PIXELS % 4 != 0) begin : g_bad_line
            $error("pixel_to_axis_packer: LINE_PIXELS must be a multiple of 4");
        end
        if (AXIS_TDATA_WIDTH != AXIS_W || PIXEL_WIDTH != PIX_W) begin : g_bad_width
            $error("pixel_to_axis_packer: only 24-bit pixels and 32-bit words are supported");
        end
    endgenerate

    phase_t             phase_reg, phase_next, eff_phase;
    logic [PIX_W-1:0]   residue_reg, residue_next, pack_residue;
    logic [CNT_W-1:0]   count_reg, count_next, eff_count;
    logic [AXIS_W-1:0]  tdata_reg, tdata_next, pack_word;
    logic               tvalid_reg, tvalid_next;
    logic               tlast_reg, tlast_next;
    logic               accept, line_end;
`ifdef PACKER_SOF_TUSER_EN
    logic               sof_pending_reg, sof_pending_next;
    logic               tuser_reg, tuser_next;
`endif

    // A ph0 pixel never produces a word, so it can be taken even with the slot stalled.
    assign pix_ready = (phase_reg == PH0) || !tvalid_reg || m_axis_tready;
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        eff_phase = phase_reg;
        eff_count = count_reg;
`ifdef PACKER_SOF_TUSER_EN
        if (pix_sof) begin
            eff_phase = PH0;
            eff_count = '0;
        end
`endif
    end

    assign line_end = (eff_count == CNT_W'(LINE_PIXELS - 1));

    always_comb begin
        pack_word    = '0;
        pack_residue = residue_reg;
        unique case (eff_phase)
            PH0: pack_residue = pix_in;
            PH1: begin
                pack_word    = {pix_in[BYTE_W-1:0], residue_reg};
                pack_residue = {{BYTE_W{1'b0}}, pix_in[PIX_W-1:BYTE_W]};
            end
            PH2: begin
                pack_word    = {pix_in[2*BYTE_W-1:0], residue_reg[2*BYTE_W-1:0]};
                pack_residue = {{2*BYTE_W{1'b0}}, pix_in[PIX_W-1:2*BYTE_W]};
            end
            PH3: begin
                pack_word    = {pix_in, residue_reg[BYTE_W-1:0]};
                pack_residue = '0;
            end
        endcase
    end

    always_comb begin
        phase_next   = phase_reg;
        residue_next = residue_reg;
        count_next   = count_reg;
        tdata_next   = tdata_reg;
        tvalid_next  = tvalid_reg;
        tlast_next   = tlast_reg;
`ifdef PACKER_SOF_TUSER_EN
        sof_pending_next = sof_pending_reg;
        tuser_next       = tuser_reg;
`endif
        if (tvalid_reg && m_axis_tready)
            tvalid_next = 1'b0;
        if (accept) begin
            phase_next   = phase_t'(eff_phase + 2'd1);
            residue_next = pack_residue;
            count_next   = line_end ? '0 : eff_count + CNT_W'(1);
            if (eff_phase == PH0) begin
`ifdef PACKER_SOF_TUSER_EN
                sof_pending_next = pix_sof;
`endif
            end else begin
                // Reload overrides the drain above, keeping tvalid high for back-to-back words.
                tdata_next  = pack_word;
                tvalid_next = 1'b1;
                tlast_next  = (eff_phase == PH3) && line_end;
`ifdef PACKER_SOF_TUSER_EN
                tuser_next = (eff_phase == PH1) && sof_pending_reg;
                if (eff_phase == PH1)
                    sof_pending_next = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg   <= PH0;
            residue_reg <= '0;
            count_reg   <= '0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
`ifdef PACKER_SOF_TUSER_EN
            sof_pending_reg <= 1'b0;
            tuser_reg       <= 1'b0;
`endif
        end else begin
            phase_reg   <= phase_next;
            residue_reg <= residue_next;
            count_reg   <= count_next;
            tdata_reg   <= tdata_next;
            tvalid_reg  <= tvalid_next;
            tlast_reg   <= tlast_next;
`ifdef PACKER_SOF_TUSER_EN
            sof_pending_reg <= sof_pending_next;
            tuser_reg       <= tuser_next;
`endif
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tlast  = tlast_reg;
`ifdef PACKER_SOF_TUSER_EN
    assign m_axis_tuser  = tuser_reg;
`endif

endmodule

// File: tb/tb_pixel_to_axis_packer.sv
// Bench for pixel_to_axis_packer: two instances (4 and 8 pixels/line) share stimulus;
// outputs are checked against a byte-stream reference model. PACKER_SOF_TUSER_EN adds SOF tests.
module tb_pixel_to_axis_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        tready = 1'b0;
    logic        pix_ready_a, pix_ready_b;
    logic        tvalid_a, tvalid_b, tlast_a, tlast_b, tuser_a, tuser_b;
    logic [31:0] tdata_a, tdata_b;

    int n_assert = 0;
    int n_fail   = 0;
    int rdy_err  = 0;
    int dual_err = 0;
    int model_phase = 0;

    logic [23:0] src_q[$];
    logic        sof_src[$];
    logic [23:0] acc_pix[$];
    logic        acc_sof[$];
    logic [31:0] w_data[$];
    logic        w_la[$], w_lb[$], w_user[$];

    always #5 clk = ~clk;

    pixel_to_axis_packer #(.AXIS_TDATA_WIDTH(32), .PIXEL_WIDTH(24), .LINE_PIXELS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready_a),
        .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a), .m_axis_tready(tready), .m_axis_tlast(tlast_a)
`ifdef PACKER_SOF_TUSER_EN
        , .pix_sof(pix_sof), .m_axis_tuser(tuser_a)
`endif
    );

    pixel_to_axis_packer #(.AXIS_TDATA_WIDTH(32), .PIXEL_WIDTH(24), .LINE_PIXELS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready), .m_axis_tlast(tlast_b)
`ifdef PACKER_SOF_TUSER_EN
        , .pix_sof(pix_sof), .m_axis_tuser(tuser_b)
`endif
    );

`ifndef PACKER_SOF_TUSER_EN
    assign tuser_a = 1'b0;
    assign tuser_b = 1'b0;
`endif

    // Records handshakes and tracks the group phase (pixels since reset/SOF, mod 4).
    always @(posedge clk) begin
        if (!rst_n) begin
            model_phase = 0;
        end else begin
            if (pix_ready_a !== ((model_phase == 0) || !tvalid_a || tready) || pix_ready_b !== pix_ready_a)
                rdy_err++;
            if (tvalid_b !== tvalid_a || (tvalid_a && (tdata_b !== tdata_a || tuser_b !== tuser_a)))
                dual_err++;
            if (pix_valid && pix_ready_a) begin
                acc_pix.push_back(pix_in);
                acc_sof.push_back(pix_sof);
                model_phase = pix_sof ? 1 : (model_phase + 1) % 4;
            end
            if (tvalid_a && tready) begin
                w_data.push_back(tdata_a);
                w_la.push_back(tlast_a);
                w_lb.push_back(tlast_b);
                w_user.push_back(tuser_a);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        src_q.delete(); sof_src.delete(); acc_pix.delete(); acc_sof.delete();
        w_data.delete(); w_la.delete(); w_lb.delete(); w_user.delete();
    endtask

    task automatic clr();
        @(negedge clk) rst_n = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; tready = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        clear_q();
    endtask

    task automatic step(input logic v, input logic [23:0] p, input logic s, input logic r);
        @(negedge clk);
        pix_valid = v; pix_in = p; pix_sof = s; tready = r;
        #1;
    endtask

    task automatic run(input string tag, input int vpct, input int rpct, output int cyc);
        int sent;
        sent = 0;
        cyc = 0;
        while (sent < src_q.size() && cyc < 20000) begin
            @(negedge clk);
            pix_valid = ($urandom_range(99) < vpct);
            tready    = ($urandom_range(99) < rpct);
            pix_in    = src_q[sent];
            pix_sof   = sof_src[sent];
            #1;
            if (pix_valid && pix_ready_a) sent++;
            cyc++;
        end
        check({tag, " pixels sent"}, sent, src_q.size());
    endtask

    task automatic drain(input string tag);
        repeat (4) begin
            @(negedge clk);
            pix_valid = 1'b0; pix_sof = 1'b0; tready = 1'b1;
        end
        #1;
        check({tag, " drained"}, tvalid_a, 1'b0);
    endtask

    // Reference: accepted pixels become a little-endian byte stream cut into 4-byte words.
    task automatic check_stream(input string tag);
        logic [7:0]  bq[$];
        logic [31:0] ew[$];
        logic        ela[$], elb[$], eu[$];
        int          c;
        logic        pend;
        c = 0;
        pend = 1'b0;
        for (int i = 0; i < acc_pix.size(); i++) begin
            if (acc_sof[i]) begin
                bq.delete();
                c = 0;
                pend = 1'b1;
            end
            for (int b = 0; b < 3; b++) bq.push_back(acc_pix[i][8*b +: 8]);
            if (bq.size() >= 4) begin
                ew.push_back({bq[3], bq[2], bq[1], bq[0]});
                repeat (4) void'(bq.pop_front());
                ela.push_back(c % 4 == 3);
                elb.push_back(c % 8 == 7);
                eu.push_back(pend);
                pend = 1'b0;
            end
            c++;
        end
        check({tag, " word count"}, w_data.size(), ew.size());
        for (int i = 0; i < ew.size() && i < w_data.size(); i++) begin
            check($sformatf("%s w%0d data", tag, i), w_data[i], ew[i]);
            check($sformatf("%s w%0d tlast4", tag, i), w_la[i], ela[i]);
            check($sformatf("%s w%0d tlast8", tag, i), w_lb[i], elb[i]);
`ifdef PACKER_SOF_TUSER_EN
            check($sformatf("%s w%0d tuser", tag, i), w_user[i], eu[i]);
`endif
        end
        check({tag, " pix_ready rule"}, rdy_err, 0);
        check({tag, " instances agree"}, dual_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, cnt_a, cnt_b;
        logic [23:0] a_pix [6];
        a_pix[0] = 24'h030201; a_pix[1] = 24'h060504; a_pix[2] = 24'h090807;
        a_pix[3] = 24'h0C0B0A; a_pix[4] = 24'h0F0E0D; a_pix[5] = 24'h121110;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset tvalid", tvalid_a, 1'b0);
        check("reset tdata", tdata_a, 32'h0);
        check("reset tlast", tlast_a, 1'b0);
        check("reset tuser", tuser_a, 1'b0);
        check("reset pix_ready", pix_ready_a, 1'b1);
        @(negedge clk) rst_n = 1'b1;

        // 1: basic packing
        clr();
        for (int i = 0; i < 4; i++) begin src_q.push_back(a_pix[i]); sof_src.push_back(1'b0); end
        run("t1", 100, 100, cyc);
        drain("t1");
        check("t1 w0", w_data[0], 32'h04030201);
        check("t1 w1", w_data[1], 32'h08070605);
        check("t1 w2", w_data[2], 32'h0C0B0A09);
        check_stream("t1");
        $display("t1 basic: %0d words", w_data.size());

        // 2: two 8-pixel lines, full throughput
        clr();
        for (int i = 0; i < 16; i++) begin src_q.push_back(24'($urandom)); sof_src.push_back(1'b0); end
        run("t2", 100, 100, cyc);
        drain("t2");
        check("t2 cycles", cyc, 16);
        check("t2 tlast8 w6", w_lb[5], 1'b1);
        check("t2 tlast8 w12", w_lb[11], 1'b1);
        cnt_b = 0;
        foreach (w_lb[i]) cnt_b += int'(w_lb[i]);
        check("t2 tlast8 count", cnt_b, 2);
        check_stream("t2");
        $display("t2 lines: %0d words, %0d tlast", w_data.size(), cnt_b);

        // 3: backpressure in the middle of a group
        clr();
        step(1'b1, a_pix[0], 1'b0, 1'b1);
        step(1'b1, a_pix[1], 1'b0, 1'b1);
        step(1'b1, a_pix[2], 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, a_pix[3], 1'b0, 1'b0);
            check($sformatf("t3 stall%0d pix_ready", k), pix_ready_a, 1'b0);
            check($sformatf("t3 stall%0d tvalid", k), tvalid_a, 1'b1);
            check($sformatf("t3 stall%0d tdata", k), tdata_a, 32'h08070605);
            check($sformatf("t3 stall%0d tlast", k), tlast_a, 1'b0);
        end
        step(1'b1, a_pix[3], 1'b0, 1'b1);
        check("t3 release pix_ready", pix_ready_a, 1'b1);
        step(1'b1, a_pix[4], 1'b0, 1'b0);
        check("t3 ph0 while stalled", pix_ready_a, 1'b1);
        check("t3 ph3 word tlast", tlast_a, 1'b1);
        step(1'b1, a_pix[5], 1'b0, 1'b0);
        check("t3 ph1 while stalled", pix_ready_a, 1'b0);
        step(1'b1, a_pix[5], 1'b0, 1'b1);
        drain("t3");
        check("t3 accepted count", acc_pix.size(), 6);
        for (int i = 0; i < 6 && i < acc_pix.size(); i++)
            check($sformatf("t3 pixel%0d", i), acc_pix[i], a_pix[i]);
        check_stream("t3");
        $display("t3 backpressure: %0d words", w_data.size());

        // 4: random valid/ready over 1000 pixels
        clr();
        for (int i = 0; i < 1000; i++) begin src_q.push_back(24'($urandom)); sof_src.push_back(1'b0); end
        run("t4", 70, 60, cyc);
        drain("t4");
        cnt_a = 0; cnt_b = 0;
        foreach (w_la[i]) begin cnt_a += int'(w_la[i]); cnt_b += int'(w_lb[i]); end
        check("t4 words", w_data.size(), 750);
        check("t4 tlast4 count", cnt_a, 250);
        check("t4 tlast8 count", cnt_b, 125);
        check_stream("t4");
        $display("t4 random: %0d words, %0d cycles", w_data.size(), cyc);

        // 5: asynchronous reset after two pixels
        clr();
        step(1'b1, 24'hA1A2A3, 1'b0, 1'b0);
        step(1'b1, 24'hB1B2B3, 1'b0, 1'b0);
        step(1'b0, 24'h0, 1'b0, 1'b0);
        check("t5 slot loaded", tvalid_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async tvalid", tvalid_a, 1'b0);
        check("t5 async tdata", tdata_a, 32'h0);
        check("t5 async tlast", tlast_a, 1'b0);
        check("t5 async tvalid8", tvalid_b, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) begin src_q.push_back(24'($urandom)); sof_src.push_back(1'b0); end
        run("t5", 100, 100, cyc);
        drain("t5");
        check("t5 fresh w0", w_data[0], {src_q[1][7:0], src_q[0]});
        check_stream("t5");
        $display("t5 reset: %0d words", w_data.size());

`ifdef PACKER_SOF_TUSER_EN
        // 6: SOF on the third pixel of a group forces resync
        clr();
        for (int i = 0; i < 6; i++) begin src_q.push_back(24'($urandom)); sof_src.push_back(i == 2); end
        run("t6", 100, 100, cyc);
        drain("t6");
        check("t6 words", w_data.size(), 4);
        check("t6 w0 tuser", w_user[0], 1'b0);
        check("t6 w1 tuser", w_user[1], 1'b1);
        check("t6 w1 low bytes", {8'h0, w_data[1][23:0]}, {8'h0, src_q[2]});
        check_stream("t6");
        $display("t6 sof: %0d words", w_data.size());
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
